// File: rtl/address_unit.sv
// address_unit -- program counter, address register and operand temp
// registers for an 8-bit-data CPU with an ADDR_W-bit address space.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active low; overrides every strobe
//   data_in[7:0]   CPU data bus, source for TH/TL operand bytes
//   PC_load        PC <= {TH,TL}
//   PC_inc         PC <= PC + 1 (PC_load wins when both are set)
//   AR_load        AR <= AB_sel ? PC : {TH,TL}
//   AR_inc         AR <= AR + 1 (AR_load wins when both are set)
//   TL_load        TL <= data_in
//   TH_load        TH <= data_in[ADDR_W-9:0]
//   AB_sel         AR_load source select (1 = PC, 0 = temp)
//   bp_we          breakpoint write: store bp_data, arm, clear bp_hit
//   bp_data        breakpoint address
//   addr_out       AR
//   pc_out         PC
//   temp_out       {TH,TL}
//   pc_wrap        one-cycle pulse after PC incremented past all-ones
//   bp_hit         sticky flag: AR was loaded from PC at the breakpoint
//
// Optional feature: define ADDRESS_UNIT_BREAKPOINT_EN to build the
// breakpoint comparator. Without it the bp_* inputs are ignored and
// bp_hit is tied low.
//
// All outputs come straight from registers; no strobe reaches an output
// combinationally.

module address_unit #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data_in,
  input  logic              PC_load,
  input  logic              PC_inc,
  input  logic              AR_load,
  input  logic              AR_inc,
  input  logic              TL_load,
  input  logic              TH_load,
  input  logic              AB_sel,
  input  logic              bp_we,
  input  logic [ADDR_W-1:0] bp_data,
  output logic [ADDR_W-1:0] addr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] temp_out,
  output logic              pc_wrap,
  output logic              bp_hit
);

  localparam int TH_W = ADDR_W - 8;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ar_q, ar_d;
  logic [TH_W-1:0]   th_q, th_d;
  logic [7:0]        tl_q, tl_d;
  logic              wrap_q, wrap_d;
  logic [ADDR_W-1:0] temp;

  assign temp = {th_q, tl_q};

  always_comb begin
    pc_d   = pc_q;
    ar_d   = ar_q;
    th_d   = th_q;
    tl_d   = tl_q;
    wrap_d = 1'b0;

    if (TH_load) th_d = data_in[TH_W-1:0];
    if (TL_load) tl_d = data_in;

    // Loads sample the pre-edge temp/PC, so a TL fetch and a PC load in
    // the same cycle see the old operand.
    if (PC_load) begin
      pc_d = temp;
    end else if (PC_inc) begin
      pc_d   = pc_q + ADDR_W'(1);
      wrap_d = &pc_q;
    end

    if (AR_load)     ar_d = AB_sel ? pc_q : temp;
    else if (AR_inc) ar_d = ar_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      ar_q   <= RESET_PC;
      th_q   <= '0;
      tl_q   <= '0;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ar_q   <= ar_d;
      th_q   <= th_d;
      tl_q   <= tl_d;
      wrap_q <= wrap_d;
    end
  end

  assign addr_out = ar_q;
  assign pc_out   = pc_q;
  assign temp_out = temp;
  assign pc_wrap  = wrap_q;

`ifdef ADDRESS_UNIT_BREAKPOINT_EN
  logic [ADDR_W-1:0] bp_addr_q, bp_addr_d;
  logic              bp_en_q, bp_en_d;
  logic              bp_hit_q, bp_hit_d;

  always_comb begin
    bp_addr_d = bp_addr_q;
    bp_en_d   = bp_en_q;
    bp_hit_d  = bp_hit_q;
    // A write re-arms and clears the flag; it takes priority over a
    // coincident hit so software always sees a clean state after writing.
    if (bp_we) begin
      bp_addr_d = bp_data;
      bp_en_d   = 1'b1;
      bp_hit_d  = 1'b0;
    end else if (bp_en_q && AR_load && AB_sel && (pc_q == bp_addr_q)) begin
      bp_hit_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bp_addr_q <= '0;
      bp_en_q   <= 1'b0;
      bp_hit_q  <= 1'b0;
    end else begin
      bp_addr_q <= bp_addr_d;
      bp_en_q   <= bp_en_d;
      bp_hit_q  <= bp_hit_d;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  logic bp_unused;
  assign bp_unused = ^{bp_we, bp_data};
  assign bp_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_address_unit.sv
module tb_address_unit;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        data_in;
  logic              PC_load, PC_inc, AR_load, AR_inc, TL_load, TH_load, AB_sel;
  logic              bp_we;
  logic [ADDR_W-1:0] bp_data;
  logic [ADDR_W-1:0] addr_out, pc_out, temp_out;
  logic              pc_wrap, bp_hit;

  int tests = 0;
  int fails = 0;

`ifdef ADDRESS_UNIT_BREAKPOINT_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  address_unit #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .data_in(data_in),
    .PC_load(PC_load), .PC_inc(PC_inc), .AR_load(AR_load), .AR_inc(AR_inc),
    .TL_load(TL_load), .TH_load(TH_load), .AB_sel(AB_sel),
    .bp_we(bp_we), .bp_data(bp_data),
    .addr_out(addr_out), .pc_out(pc_out), .temp_out(temp_out),
    .pc_wrap(pc_wrap), .bp_hit(bp_hit)
  );

  always #5 clk = ~clk;

  task automatic idle();
    PC_load = 0; PC_inc = 0; AR_load = 0; AR_inc = 0;
    TL_load = 0; TH_load = 0; AB_sel = 0; bp_we = 0;
  endtask

  // One clock edge, then sample 1 time unit later; strobes clear afterwards.
  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_reset();
    rst = 0; data_in = 8'h00; bp_data = '0; idle();
    tick(); tick();
    tests++; if (pc_out   !== 16'h0000) begin fails++; $display("FAIL reset_pc: got %h want 0000", pc_out); end
    tests++; if (addr_out !== 16'h0000) begin fails++; $display("FAIL reset_ar: got %h want 0000", addr_out); end
    tests++; if (temp_out !== 16'h0000) begin fails++; $display("FAIL reset_temp: got %h want 0000", temp_out); end
    tests++; if (pc_wrap  !== 1'b0)     begin fails++; $display("FAIL reset_wrap: got %b want 0", pc_wrap); end
    tests++; if (bp_hit   !== 1'b0)     begin fails++; $display("FAIL reset_bp: got %b want 0", bp_hit); end
    rst = 1;
  endtask

  task automatic test_pc_inc();
    for (int i = 0; i < 3; i++) begin PC_inc = 1; tick(); end
    tests++; if (pc_out   !== 16'h0003) begin fails++; $display("FAIL inc3_pc: got %h want 0003", pc_out); end
    tests++; if (addr_out !== 16'h0000) begin fails++; $display("FAIL inc3_ar: got %h want 0000", addr_out); end
    tests++; if (pc_wrap  !== 1'b0)     begin fails++; $display("FAIL inc3_wrap: got %b want 0", pc_wrap); end
  endtask

  task automatic test_load_path();
    data_in = 8'h12; TH_load = 1; tick();
    data_in = 8'h34; TL_load = 1; PC_inc = 1; tick();
    tests++; if (temp_out !== 16'h1234) begin fails++; $display("FAIL temp_1234: got %h want 1234", temp_out); end
    tests++; if (pc_out   !== 16'h0004) begin fails++; $display("FAIL tl_with_inc_pc: got %h want 0004", pc_out); end
    PC_load = 1; tick();
    tests++; if (pc_out   !== 16'h1234) begin fails++; $display("FAIL pc_load: got %h want 1234", pc_out); end
    tick();
    tests++; if (pc_out   !== 16'h1234) begin fails++; $display("FAIL hold_pc: got %h want 1234", pc_out); end
    tests++; if (temp_out !== 16'h1234) begin fails++; $display("FAIL hold_temp: got %h want 1234", temp_out); end
    // Both bytes in one cycle
    data_in = 8'hA5; TH_load = 1; TL_load = 1; tick();
    tests++; if (temp_out !== 16'hA5A5) begin fails++; $display("FAIL th_tl_same: got %h want a5a5", temp_out); end
  endtask

  task automatic test_ar();
    data_in = 8'h80; TH_load = 1; tick();
    data_in = 8'h00; TL_load = 1; tick();
    AR_load = 1; AB_sel = 0; tick();
    tests++; if (addr_out !== 16'h8000) begin fails++; $display("FAIL ar_load_temp: got %h want 8000", addr_out); end
    AR_inc = 1; tick();
    tests++; if (addr_out !== 16'h8001) begin fails++; $display("FAIL ar_inc: got %h want 8001", addr_out); end
    AR_load = 1; AR_inc = 1; tick();
    tests++; if (addr_out !== 16'h8000) begin fails++; $display("FAIL ar_load_wins: got %h want 8000", addr_out); end
    AR_load = 1; AB_sel = 1; tick();
    tests++; if (addr_out !== 16'h1234) begin fails++; $display("FAIL ar_load_pc: got %h want 1234", addr_out); end
    data_in = 8'h55; TL_load = 1; AR_inc = 1; tick();
    tests++; if (addr_out !== 16'h1235) begin fails++; $display("FAIL tl_with_arinc_ar: got %h want 1235", addr_out); end
    tests++; if (temp_out !== 16'h8055) begin fails++; $display("FAIL tl_with_arinc_temp: got %h want 8055", temp_out); end
    // AR wrap past all-ones
    data_in = 8'hFF; TH_load = 1; TL_load = 1; tick();
    AR_load = 1; AB_sel = 0; tick();
    AR_inc = 1; tick();
    tests++; if (addr_out !== 16'h0000) begin fails++; $display("FAIL ar_wrap: got %h want 0000", addr_out); end
  endtask

  task automatic test_wrap();
    // temp is FFFF from the previous test
    PC_load = 1; tick();
    tests++; if (pc_out  !== 16'hFFFF) begin fails++; $display("FAIL pc_ffff: got %h want ffff", pc_out); end
    tests++; if (pc_wrap !== 1'b0)     begin fails++; $display("FAIL wrap_pre: got %b want 0", pc_wrap); end
    PC_inc = 1; tick();
    tests++; if (pc_out  !== 16'h0000) begin fails++; $display("FAIL pc_wrapped: got %h want 0000", pc_out); end
    tests++; if (pc_wrap !== 1'b1)     begin fails++; $display("FAIL wrap_pulse: got %b want 1", pc_wrap); end
    tick();
    tests++; if (pc_wrap !== 1'b0)     begin fails++; $display("FAIL wrap_one_cycle: got %b want 0", pc_wrap); end
    PC_load = 1; tick();
    data_in = 8'h0A; TH_load = 1; tick();
    data_in = 8'hBC; TL_load = 1; tick();
    PC_inc = 1; PC_load = 1; tick();
    tests++; if (pc_out  !== 16'h0ABC) begin fails++; $display("FAIL load_beats_inc: got %h want 0abc", pc_out); end
    tests++; if (pc_wrap !== 1'b0)     begin fails++; $display("FAIL no_wrap_on_load: got %b want 0", pc_wrap); end
  endtask

  task automatic test_breakpoint();
    rst = 0; tick(); rst = 1;
    bp_we = 1; bp_data = 16'h0010; tick();
    for (int i = 0; i < 16; i++) begin PC_inc = 1; tick(); end
    tests++; if (pc_out !== 16'h0010) begin fails++; $display("FAIL bp_pc: got %h want 0010", pc_out); end
    tests++; if (bp_hit !== 1'b0)     begin fails++; $display("FAIL bp_pre: got %b want 0", bp_hit); end
    // Loading AR from temp (0) does not hit, even though PC matches
    AR_load = 1; AB_sel = 0; tick();
    tests++; if (bp_hit !== 1'b0)     begin fails++; $display("FAIL bp_temp_src: got %b want 0", bp_hit); end
    AR_load = 1; AB_sel = 1; tick();
    tests++; if (bp_hit !== BP)       begin fails++; $display("FAIL bp_hit: got %b want %b", bp_hit, BP); end
    PC_inc = 1; tick(); tick();
    tests++; if (bp_hit !== BP)       begin fails++; $display("FAIL bp_sticky: got %b want %b", bp_hit, BP); end
    bp_we = 1; bp_data = 16'h0100; tick();
    tests++; if (bp_hit !== 1'b0)     begin fails++; $display("FAIL bp_we_clear: got %b want 0", bp_hit); end
  endtask

  task automatic test_reset_override();
    data_in = 8'h77; TH_load = 1; TL_load = 1; tick();
    PC_load = 1; tick();
    tests++; if (pc_out !== 16'h7777) begin fails++; $display("FAIL pre_rst_pc: got %h want 7777", pc_out); end
    data_in = 8'h99; PC_load = 1; TL_load = 1; AR_inc = 1; rst = 0; tick();
    tests++; if (pc_out   !== 16'h0000) begin fails++; $display("FAIL rst_override_pc: got %h want 0000", pc_out); end
    tests++; if (temp_out !== 16'h0000) begin fails++; $display("FAIL rst_override_temp: got %h want 0000", temp_out); end
    tests++; if (addr_out !== 16'h0000) begin fails++; $display("FAIL rst_override_ar: got %h want 0000", addr_out); end
    rst = 1;
  endtask

  initial begin
    test_reset();
    test_pc_inc();
    test_load_path();
    test_ar();
    test_wrap();
    test_breakpoint();
    test_reset_override();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
